// File: rtl/pll_sel_ui.sv
// Front-panel PLL frequency selector.
// UP/DOWN buttons are synchronised and debounced. Each accepted press steps a
// wrapping frequency index and issues one PLL_ADDR/PLL_CHG request. The block
// then waits for the PLL to re-lock before it accepts another press. The index
// and a lock-error flag are shown on two 7-segment digits.
//
// Request/lock handshake with the PLL control stage:
//   - PLL_ADDR is stable before PLL_CHG rises and holds until the next request.
//   - PLL_CHG is a single-cycle strobe.
//   - PLL_LOCK is ignored for HOLDOFF cycles after the strobe. After that, the
//     first cycle with PLL_LOCK=1 completes the request.
//   - If lock does not arrive within LOCK_TO cycles, the request completes with
//     ERR set. No retry is made.
//   - BUSY is high from the strobe cycle until completion. Presses seen while
//     BUSY are dropped.
module pll_sel_ui #(
    parameter int DEB_CNT = 250000,
    parameter int NUM_SET = 16,
    parameter int HOLDOFF = 64,
    parameter int LOCK_TO = 1000000,
    parameter int SEG_AL  = 1
) (
    input  logic       CLK,
    input  logic       RSTXO,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    input  logic       PLL_LOCK,
    output logic [3:0] PLL_ADDR,
    output logic       PLL_CHG,
    output logic       BUSY,
    output logic       ERR,
    output logic [6:0] DIGIT0,
    output logic [6:0] DIGIT1
);

    // Debounce counter width covers 0..DEB_CNT-1.
    localparam int DW   = $clog2(DEB_CNT);
    // One timer serves both HOLD and WAITL, so it is sized for the longer one.
    localparam int TMAX = (HOLDOFF > LOCK_TO) ? HOLDOFF : LOCK_TO;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [3:0] IDX_MAX = 4'(NUM_SET - 1);
    localparam logic [6:0] SEG_INV = (SEG_AL != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_E   = 7'h79;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHG   = 2'd1,
        S_HOLD  = 2'd2,
        S_WAITL = 2'd3
    } state_t;

    // Bit 0 is the UP button and bit 1 is the DOWN button.
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_db;
    logic [1:0]    r_db_d;
    logic [1:0]    r_press;
    logic [DW-1:0] r_dcnt [2];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          r_chg;
    logic          r_busy;
    logic [6:0]    r_dig0;
    logic [6:0]    r_dig1;

    logic [3:0]    w_ones;
    logic          w_tens;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {BTN_DN, BTN_UP};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after DEB_CNT consecutive differing cycles.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            r_db <= '0;
            for (int i = 0; i < 2; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DW'(DEB_CNT - 1)) begin
                    r_db[i]   <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Press event: one registered pulse the cycle after a debounced rising edge.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            r_db_d  <= '0;
            r_press <= '0;
        end else begin
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    // FSM state, index, timer, error flag and strobe/busy registers.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_chg   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_err   <= w_err_nxt;
            r_chg   <= (w_state_nxt == S_CHG);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state logic: step the index on a lone press, then run holdoff and the lock wait.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tcnt_nxt  = '0;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                // Simultaneous UP and DOWN presses cancel each other.
                if (r_press[0] ^ r_press[1]) begin
                    if (r_press[0]) begin
                        w_idx_nxt = (r_idx == IDX_MAX) ? 4'd0 : r_idx + 4'd1;
                    end else begin
                        w_idx_nxt = (r_idx == 4'd0) ? IDX_MAX : r_idx - 4'd1;
                    end
                    w_state_nxt = S_CHG;
                end
            end
            S_CHG: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_tcnt == TW'(HOLDOFF - 1)) begin
                    w_state_nxt = S_WAITL;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            S_WAITL: begin
                // A lock in the last allowed cycle still counts as success.
                if (PLL_LOCK) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TW'(LOCK_TO - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Active-high {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // The index never exceeds 15, so the tens digit is either 0 or 1.
    assign w_tens = (r_idx >= 4'd10);
    assign w_ones = w_tens ? (r_idx - 4'd10) : r_idx;

    // Registered display: ones digit, and a tens digit that shows 'E' when the lock timed out.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            r_dig0 <= 7'h3F ^ SEG_INV;
            r_dig1 <= SEG_INV;
        end else begin
            r_dig0 <= seg7(w_ones) ^ SEG_INV;
            if (r_err) begin
                r_dig1 <= SEG_E ^ SEG_INV;
            end else if (w_tens) begin
                r_dig1 <= seg7(4'd1) ^ SEG_INV;
            end else begin
                r_dig1 <= SEG_INV;
            end
        end
    end

    assign PLL_ADDR = r_idx;
    assign PLL_CHG  = r_chg;
    assign BUSY     = r_busy;
    assign ERR      = r_err;
    assign DIGIT0   = r_dig0;
    assign DIGIT1   = r_dig1;

endmodule

// File: tb/tb_pll_sel_ui.sv
// Testbench for pll_sel_ui.
// The bench plays the role of the PLL. Expected behaviour comes from a
// press-level model: press lengths, modular index arithmetic, lock timing
// arithmetic and a segment table. Each PLL_CHG pops the expected address
// from exp_q.
module tb_pll_sel_ui;

    localparam int DEB_CNT = 4;
    localparam int NUM_SET = 16;
    localparam int HOLDOFF = 8;
    localparam int LOCK_TO = 32;
    localparam int SEG_AL  = 1;
    localparam int NEVER   = 1000;   // lock delay meaning "lock never returns"
    localparam int WIN     = 64;     // cycles observed per press scenario

    logic       clk;
    logic       rstxo;
    logic       btn_up;
    logic       btn_dn;
    logic       pll_lock;
    logic [3:0] pll_addr;
    logic       pll_chg;
    logic       busy;
    logic       err;
    logic [6:0] digit0;
    logic [6:0] digit1;

    int n_checks = 0;
    int n_errors = 0;

    // Press-level model state.
    int         m_idx = 0;
    bit         m_err = 1'b0;
    logic [3:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    pll_sel_ui #(
        .DEB_CNT (DEB_CNT),
        .NUM_SET (NUM_SET),
        .HOLDOFF (HOLDOFF),
        .LOCK_TO (LOCK_TO),
        .SEG_AL  (SEG_AL)
    ) dut (
        .CLK      (clk),
        .RSTXO    (rstxo),
        .BTN_UP   (btn_up),
        .BTN_DN   (btn_dn),
        .PLL_LOCK (pll_lock),
        .PLL_ADDR (pll_addr),
        .PLL_CHG  (pll_chg),
        .BUSY     (busy),
        .ERR      (err),
        .DIGIT0   (digit0),
        .DIGIT1   (digit1)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_dig0(input int idx);
        logic [6:0] v;
        v = seg_tab[idx % 10];
        return (SEG_AL != 0) ? ~v : v;
    endfunction

    function automatic logic [6:0] exp_dig1(input int idx, input bit e);
        logic [6:0] v;
        if (e)
            v = 7'h79;
        else if (idx / 10 == 0)
            v = 7'h00;
        else
            v = seg_tab[idx / 10];
        return (SEG_AL != 0) ? ~v : v;
    endfunction

    task automatic check_idle(input string where);
        check({where, "_addr"}, 32'(pll_addr), 32'(m_idx));
        check({where, "_chg"},  32'(pll_chg),  32'(0));
        check({where, "_busy"}, 32'(busy),     32'(0));
        check({where, "_err"},  32'(err),      32'(m_err));
        check({where, "_dig0"}, 32'(digit0),   32'(exp_dig0(m_idx)));
        check({where, "_dig1"}, 32'(digit1),   32'(exp_dig1(m_idx, m_err)));
    endtask

    task automatic check_reset_values(input string where);
        check({where, "_addr"}, 32'(pll_addr), 32'(0));
        check({where, "_chg"},  32'(pll_chg),  32'(0));
        check({where, "_busy"}, 32'(busy),     32'(0));
        check({where, "_err"},  32'(err),      32'(0));
        check({where, "_dig0"}, 32'(digit0),   32'h40);
        check({where, "_dig1"}, 32'(digit1),   32'h7F);
    endtask

    // Count PLL_CHG pulses over n cycles. None are expected in these windows.
    task automatic expect_quiet(input string where, input int n);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pll_chg !== 1'b0) pulses++;
        end
        check({where, "_no_chg"}, 32'(pulses), 32'(0));
    endtask

    // Drive one press scenario, act as the PLL, and score it.
    // hold: cycles the button(s) stay high.
    // d: lock returns d cycles after HOLD ends (NEVER means no lock).
    // repress: press the same button again while the request is in progress.
    task automatic run_press(input bit up, input bit dn, input int hold, input int d,
                             input bit repress);
        int chg_at;
        int n_chg;
        int busy_low;
        int rep_at;
        int rep_end;
        bit accept;
        bit err_before;
        bit err_after;
        accept     = (up ^ dn) && (hold >= DEB_CNT);
        err_before = m_err;
        err_after  = m_err;
        if (accept) begin
            if (up) m_idx = (m_idx + 1) % NUM_SET;
            else    m_idx = (m_idx + NUM_SET - 1) % NUM_SET;
            exp_q.push_back(4'(m_idx));
            err_after = (d == NEVER);
        end
        m_err    = err_after;
        chg_at   = -1;
        n_chg    = 0;
        busy_low = 0;
        rep_at   = hold + DEB_CNT + 3;
        rep_end  = rep_at + DEB_CNT + 1;
        btn_up   = up;
        btn_dn   = dn;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (pll_chg === 1'b1) begin
                n_chg++;
                if (exp_q.size() > 0)
                    check("chg_addr", 32'(pll_addr), 32'(exp_q.pop_front()));
                else
                    check("chg_spurious", 32'(pll_chg), 32'(0));
                if (chg_at < 0) begin
                    chg_at = k;
                    // 2 sync + DEB_CNT debounce + 1 press register + 1 FSM step
                    check("chg_latency", 32'(k), 32'(DEB_CNT + 4));
                    if (d == NEVER)
                        busy_low = k + 1 + HOLDOFF + LOCK_TO;
                    else
                        busy_low = k + 1 + HOLDOFF + ((d > 1) ? d : 1);
                end
                pll_lock = 1'b0;
            end
            if (chg_at > 0 && k >= chg_at) begin
                check("busy", 32'(busy), 32'(k < busy_low));
                check("err",  32'(err),  32'((k < busy_low) ? err_before : err_after));
                if (d != NEVER && k == chg_at + HOLDOFF + d) pll_lock = 1'b1;
            end
            if (k == hold) begin
                btn_up = 1'b0;
                btn_dn = 1'b0;
            end
            if (repress && k == rep_at) begin
                btn_up = up;
                btn_dn = dn;
            end
            if (repress && k == rep_end) begin
                btn_up = 1'b0;
                btn_dn = 1'b0;
            end
        end
        check("chg_count", 32'(n_chg), 32'(accept ? 1 : 0));
        check("q_drained", 32'(exp_q.size()), 32'(0));
        check_idle("idle");
    endtask

    // Start a press, then assert reset in the middle of HOLD.
    task automatic run_reset_mid_hold();
        int  chg_at;
        bit  done;
        chg_at = -1;
        done   = 1'b0;
        m_idx  = (m_idx + 1) % NUM_SET;
        exp_q.push_back(4'(m_idx));
        btn_up = 1'b1;
        for (int k = 1; k <= WIN && !done; k++) begin
            @(negedge clk);
            if (pll_chg === 1'b1 && chg_at < 0) begin
                chg_at = k;
                if (exp_q.size() > 0)
                    check("rst_chg_addr", 32'(pll_addr), 32'(exp_q.pop_front()));
                pll_lock = 1'b0;
            end
            if (k == DEB_CNT + 1) btn_up = 1'b0;
            if (chg_at > 0 && k == chg_at + 3) begin
                check("rst_busy_in_hold", 32'(busy), 32'(1));
                rstxo = 1'b0;
                #1;
                check_reset_values("rst_mid");
                done = 1'b1;
            end
        end
        check("rst_reached_hold", 32'(done), 32'(1));
        exp_q.delete();
        m_idx = 0;
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst_held");
        rstxo    = 1'b1;
        pll_lock = 1'b1;
        expect_quiet("rst_release", 20);
        check_idle("rst_after");
    endtask

    // Directed scenarios, a randomised section, then the report.
    initial begin
        int op;
        int hold;
        int d;
        rstxo    = 1'b0;
        btn_up   = 1'b0;
        btn_dn   = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rstxo = 1'b1;
        expect_quiet("por_release", 20);
        check_idle("por_idle");

        // Short glitches must never be accepted.
        for (int g = 0; g < 3; g++) run_press(1'b1, 1'b0, DEB_CNT - 1, 3, 1'b0);
        // DOWN at index 0 wraps to 15.
        run_press(1'b0, 1'b1, DEB_CNT + 2, 3, 1'b0);
        // UP held long at 15 wraps to 0, then UP again gives 1.
        run_press(1'b1, 1'b0, 20, 3, 1'b0);
        run_press(1'b1, 1'b0, 20, 3, 1'b0);
        // A second press while busy is discarded.
        run_press(1'b1, 1'b0, DEB_CNT + 2, 16, 1'b1);
        // Lock timeout sets ERR; the next successful lock clears it.
        run_press(1'b1, 1'b0, DEB_CNT + 1, NEVER, 1'b0);
        run_press(1'b0, 1'b1, DEB_CNT + 2, 5, 1'b0);
        // Lock returning during HOLD is ignored, and lock on the last WAITL cycle succeeds.
        run_press(1'b1, 1'b0, DEB_CNT, -4, 1'b0);
        run_press(1'b1, 1'b0, DEB_CNT, LOCK_TO, 1'b0);
        // UP and DOWN presses in the same cycle are ignored.
        run_press(1'b1, 1'b1, DEB_CNT + 3, 3, 1'b0);
        // Reset during HOLD.
        run_reset_mid_hold();

        // Randomised presses, glitches, double presses and timeouts.
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(4, 0));
            d  = int'($urandom_range(LOCK_TO + 6, 0)) - 6;
            case (op)
                0: run_press(1'b1, 1'b0, int'($urandom_range(DEB_CNT + 12, DEB_CNT)), d, 1'b0);
                1: run_press(1'b0, 1'b1, int'($urandom_range(DEB_CNT + 12, DEB_CNT)), d, 1'b0);
                2: begin
                    hold = int'($urandom_range(DEB_CNT - 1, 1));
                    if ($urandom_range(1, 0) == 1) run_press(1'b1, 1'b0, hold, d, 1'b0);
                    else                           run_press(1'b0, 1'b1, hold, d, 1'b0);
                end
                3: run_press(1'b1, 1'b1, int'($urandom_range(DEB_CNT + 6, DEB_CNT)), d, 1'b0);
                default: begin
                    if ($urandom_range(1, 0) == 1) run_press(1'b1, 1'b0, DEB_CNT + 1, NEVER, 1'b0);
                    else                           run_press(1'b0, 1'b1, DEB_CNT + 1, NEVER, 1'b0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
